// File: rtl/lap_history_if.sv
// Signal bundle between the stopwatch counters/buttons (master) and lap_history (slave).
// Optional delta_out exists only when LAP_HISTORY_DELTA_EN is defined.
interface lap_history_if #(
   parameter int DIGITS = 4,
   parameter int DEPTH  = 8
);
   localparam int W  = 4 * DIGITS;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   // lap, clear, recall_prev and recall_next are single-cycle pulses; there is no
   // back-pressure, every pulse is acted on at the next rising clock edge.
   logic          lap;
   logic          clear;
   logic          recall_prev;
   logic          recall_next;
   logic [W-1:0]  lap_time;
   logic [W-1:0]  lap_out;
   logic [AW-1:0] lap_sel;
   logic [CW-1:0] lap_count;
   logic          full;
   logic          overflow;
`ifdef LAP_HISTORY_DELTA_EN
   logic [W-1:0]  delta_out;
`endif

   modport master (
      output lap, clear, recall_prev, recall_next, lap_time,
      input  lap_out, lap_sel, lap_count, full, overflow
`ifdef LAP_HISTORY_DELTA_EN
      , input delta_out
`endif
   );

   modport slave (
      input  lap, clear, recall_prev, recall_next, lap_time,
      output lap_out, lap_sel, lap_count, full, overflow
`ifdef LAP_HISTORY_DELTA_EN
      , output delta_out
`endif
   );
endinterface

// File: rtl/lap_history.sv
// Circular lap memory with newest-to-oldest browsing for the stopwatch display path.
// Define LAP_HISTORY_DELTA_EN to add delta_out (split time of the viewed lap vs. the next-older lap).
module lap_history #(
   parameter int DIGITS = 4,
   parameter int DEPTH  = 8
) (
   input logic          clk,
   input logic          rst,
   lap_history_if.slave bus
);
   localparam int W   = 4 * DIGITS;
   localparam int AW  = $clog2(DEPTH);
   localparam int AW1 = AW + 1;
   localparam int CW  = $clog2(DEPTH + 1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] sel_q, sel_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic [W-1:0]  out_q, out_d;
   logic          mem_we;
   logic [CW-1:0] last_sel;
   logic          recall_step;

   // Physical slot of the entry sel steps behind the newest; wrap is explicit so
   // non-power-of-two depths address correctly.
   function automatic logic [AW-1:0] view_idx(input logic [AW-1:0] wr, input logic [AW-1:0] sel);
      logic [AW:0] t;
      t = {1'b0, wr} + AW1'(DEPTH - 1) - {1'b0, sel};
      if (t >= AW1'(DEPTH)) t = t - AW1'(DEPTH);
      return t[AW-1:0];
   endfunction

`ifdef LAP_HISTORY_DELTA_EN
   logic [W-1:0] delta_q, delta_d;

   function automatic logic [W-1:0] bcd_sub(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] r;
      logic         borrow;
      logic [4:0]   d;
      r      = '0;
      borrow = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         d = {1'b0, a[4*i +: 4]} - {1'b0, b[4*i +: 4]} - {4'b0, borrow};
         if (d[4]) begin
            d      = d + 5'd10;
            borrow = 1'b1;
         end else begin
            borrow = 1'b0;
         end
         r[4*i +: 4] = d[3:0];
      end
      return r;
   endfunction
`endif

   assign last_sel    = count_q - CW'(1);
   assign recall_step = (count_q != '0) && (bus.recall_prev ^ bus.recall_next);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      sel_d    = sel_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      out_d    = out_q;
      mem_we   = 1'b0;
`ifdef LAP_HISTORY_DELTA_EN
      delta_d  = delta_q;
`endif
      if (bus.lap) begin
         mem_we   = 1'b1;
         wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
         if (count_q == CW'(DEPTH)) begin
            ovf_d = 1'b1;
         end else begin
            count_d = count_q + CW'(1);
         end
         sel_d = '0;
         out_d = bus.lap_time;
`ifdef LAP_HISTORY_DELTA_EN
         // The current newest entry becomes the next-older one after this write.
         delta_d = (count_q == '0) ? bus.lap_time
                                   : bcd_sub(bus.lap_time, mem_q[view_idx(wr_ptr_q, '0)]);
`endif
      end else if (recall_step) begin
         if (bus.recall_prev) begin
            sel_d = (CW'(sel_q) == last_sel) ? '0 : sel_q + AW'(1);
         end else begin
            sel_d = (sel_q == '0) ? AW'(last_sel) : sel_q - AW'(1);
         end
         out_d = mem_q[view_idx(wr_ptr_q, sel_d)];
`ifdef LAP_HISTORY_DELTA_EN
         delta_d = (CW'(sel_d) == last_sel) ? out_d
                                            : bcd_sub(out_d, mem_q[view_idx(wr_ptr_q, sel_d + AW'(1))]);
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst || bus.clear) begin
         wr_ptr_q <= '0;
         sel_q    <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         out_q    <= '0;
`ifdef LAP_HISTORY_DELTA_EN
         delta_q  <= '0;
`endif
      end else begin
         wr_ptr_q <= wr_ptr_d;
         sel_q    <= sel_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         out_q    <= out_d;
`ifdef LAP_HISTORY_DELTA_EN
         delta_q  <= delta_d;
`endif
      end
   end

   // Storage has no reset; stale contents are unreachable while lap_count is 0.
   always_ff @(posedge clk) begin
      if (!rst && !bus.clear && mem_we) begin
         mem_q[wr_ptr_q] <= bus.lap_time;
      end
   end

   assign bus.lap_out   = out_q;
   assign bus.lap_sel   = sel_q;
   assign bus.lap_count = count_q;
   assign bus.full      = (count_q == CW'(DEPTH));
   assign bus.overflow  = ovf_q;
`ifdef LAP_HISTORY_DELTA_EN
   assign bus.delta_out = delta_q;
`endif
endmodule

// File: tb/tb_lap_history.sv
// Directed bench for lap_history: a queue-based history model checked every cycle plus literal expectations.
module tb_lap_history;
   localparam int DIGITS = 4;
   localparam int DEPTH  = 8;
   localparam int W      = 4 * DIGITS;
   localparam int MOD    = 10000;

   logic clk;
   logic rst;
   lap_history_if #(.DIGITS(DIGITS), .DEPTH(DEPTH)) bus ();

   lap_history #(.DIGITS(DIGITS), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;
   bit cmp_en   = 0;

   // Model: hist[0] is the newest lap, hist[size-1] the oldest.
   logic [W-1:0] hist[$];
   int           m_sel   = 0;
   logic [W-1:0] m_out   = '0;
   logic [W-1:0] m_delta = '0;
   bit           m_ovf   = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic int from_bcd(input logic [W-1:0] v);
      int r = 0;
      for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
      return r;
   endfunction

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r = '0;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic logic [W-1:0] exp_delta(input int s);
      if (s == hist.size() - 1) return hist[s];
      return to_bcd((from_bcd(hist[s]) - from_bcd(hist[s + 1]) + MOD) % MOD);
   endfunction

   always @(posedge clk) begin
      if (rst || bus.clear) begin
         hist.delete();
         m_sel = 0; m_out = '0; m_ovf = 0; m_delta = '0;
      end else if (bus.lap) begin
         hist.push_front(bus.lap_time);
         if (hist.size() > DEPTH) begin
            void'(hist.pop_back());
            m_ovf = 1;
         end
         m_sel   = 0;
         m_out   = bus.lap_time;
         m_delta = exp_delta(0);
      end else if (hist.size() > 0 && bus.recall_prev != bus.recall_next) begin
         if (bus.recall_prev) m_sel = (m_sel + 1) % hist.size();
         else                 m_sel = (m_sel + hist.size() - 1) % hist.size();
         m_out   = hist[m_sel];
         m_delta = exp_delta(m_sel);
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("lap_out",   32'(bus.lap_out),   32'(m_out));
         check("lap_sel",   32'(bus.lap_sel),   32'(m_sel));
         check("lap_count", 32'(bus.lap_count), 32'(hist.size()));
         check("full",      32'(bus.full),      32'(hist.size() == DEPTH));
         check("overflow",  32'(bus.overflow),  32'(m_ovf));
`ifdef LAP_HISTORY_DELTA_EN
         check("delta_out", 32'(bus.delta_out), 32'(m_delta));
`endif
      end
   end

   // Drives one cycle of inputs at posedge+1 and returns at the following posedge+1.
   task automatic pulse(input logic l, input logic c, input logic p, input logic n,
                        input logic r, input logic [W-1:0] t);
      bus.lap = l; bus.clear = c; bus.recall_prev = p; bus.recall_next = n;
      rst = r; bus.lap_time = t;
      @(posedge clk); #1;
      bus.lap = 0; bus.clear = 0; bus.recall_prev = 0; bus.recall_next = 0;
      rst = 0; bus.lap_time = '0;
   endtask

   task automatic do_lap(input logic [W-1:0] t);  pulse(1, 0, 0, 0, 0, t);  endtask
   task automatic do_prev();                       pulse(0, 0, 1, 0, 0, '0); endtask
   task automatic do_next();                       pulse(0, 0, 0, 1, 0, '0); endtask
   task automatic do_clear();                      pulse(0, 1, 0, 0, 0, '0); endtask

   initial begin
      rst = 1'b1;
      bus.lap = 0; bus.clear = 0; bus.recall_prev = 0; bus.recall_next = 0;
      bus.lap_time = '0;
      @(posedge clk); #1;
      cmp_en = 1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_lap_out",   32'(bus.lap_out),   32'h0);
      check("rst_lap_count", 32'(bus.lap_count), 32'h0);
      check("rst_overflow",  32'(bus.overflow),  32'h0);

      do_lap(16'h0012); do_lap(16'h0045); do_lap(16'h0103);
      check("three_count",   32'(bus.lap_count), 32'd3);
      check("three_sel",     32'(bus.lap_sel),   32'd0);
      check("three_out",     32'(bus.lap_out),   32'h0103);
      check("three_full",    32'(bus.full),      32'h0);
      do_prev(); check("prev1_out", 32'(bus.lap_out), 32'h0045);
      do_prev(); check("prev2_out", 32'(bus.lap_out), 32'h0012);
      do_prev(); check("prev_wrap_out", 32'(bus.lap_out), 32'h0103);
      check("prev_wrap_sel", 32'(bus.lap_sel), 32'd0);
      do_next(); check("next_wrap_sel", 32'(bus.lap_sel), 32'd2);
      check("next_wrap_out", 32'(bus.lap_out), 32'h0012);

      do_clear();
      for (int i = 1; i <= 9; i++) do_lap(W'(i));
      check("nine_full",     32'(bus.full),      32'h1);
      check("nine_overflow", 32'(bus.overflow),  32'h1);
      check("nine_count",    32'(bus.lap_count), 32'd8);
      do_next();
      check("oldest_sel",    32'(bus.lap_sel),   32'd7);
      check("oldest_out",    32'(bus.lap_out),   32'h0002);
      do_prev(); do_prev();
      check("browse_out",    32'(bus.lap_out),   32'h0008);

      pulse(1, 0, 1, 0, 0, 16'h0200);
      check("lap_wins_sel",  32'(bus.lap_sel),   32'd0);
      check("lap_wins_out",  32'(bus.lap_out),   32'h0200);
      check("lap_wins_ovf",  32'(bus.overflow),  32'h1);
      pulse(0, 0, 1, 1, 0, '0);
      check("both_out",      32'(bus.lap_out),   32'h0200);
      check("both_sel",      32'(bus.lap_sel),   32'd0);
      do_clear();
      check("clear_count",   32'(bus.lap_count), 32'd0);
      check("clear_ovf",     32'(bus.overflow),  32'h0);
      check("clear_out",     32'(bus.lap_out),   32'h0);
      do_prev(); check("empty_prev_out", 32'(bus.lap_out), 32'h0);
      do_next(); check("empty_next_sel", 32'(bus.lap_sel), 32'd0);
      pulse(1, 0, 0, 0, 1, 16'h0777);
      check("rst_lap_count2", 32'(bus.lap_count), 32'd0);

      do_lap(16'h0031);
      do_prev(); do_next();
      check("single_sel",    32'(bus.lap_sel),   32'd0);
      check("single_out",    32'(bus.lap_out),   32'h0031);

`ifdef LAP_HISTORY_DELTA_EN
      do_clear();
      do_lap(16'h0058); do_lap(16'h0103);
      check("delta_newest",  32'(bus.delta_out), 32'h0045);
      do_prev();
      check("delta_oldest",  32'(bus.delta_out), 32'h0058);
      do_lap(16'h0020);
      check("delta_wrap",    32'(bus.delta_out), 32'h9917);
`endif

      repeat (2) @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/lap_history.md
Name: lap_history

Overview:
- Multi-entry lap memory for the stopwatch.
- Captures a full multi-digit BCD lap time on each lap pulse into a circular buffer of DEPTH entries.
- Lets the user browse stored laps newest-to-oldest with prev/next buttons.
- Sits between the dec_counter chain (source of lap_time) and the seven-segment display mux (consumer of lap_out).

Parameters:
- DIGITS, 4: number of BCD digits per lap time; data width is 4*DIGITS.
- DEPTH, 8: number of stored laps; legal range 2..64, power of two not required.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- lap  input  1  one-cycle capture pulse (already debounced/edge-detected)
- clear  input  1  one-cycle pulse; empties history, keeps overflow cleared
- recall_prev  input  1  one-cycle pulse; step view toward older lap
- recall_next  input  1  one-cycle pulse; step view toward newer lap
- lap_time  input  4*DIGITS  current BCD time from counters
- lap_out  output  4*DIGITS  registered BCD lap currently viewed
- lap_sel  output  $clog2(DEPTH)  view index, 0 = newest
- lap_count  output  $clog2(DEPTH+1)  number of valid entries, 0..DEPTH
- full  output  1  lap_count == DEPTH
- overflow  output  1  sticky: an entry was overwritten since last rst/clear

Behaviour:
- Single clock domain. Reset is synchronous and active-high. All outputs are registered.
- Reset values: lap_out=0, lap_sel=0, lap_count=0, full=0, overflow=0, write pointer=0. Memory contents are don't-care; they are never visible when lap_count=0.
- Event priority per cycle: rst > clear > lap > recall_prev/recall_next.
- clear: same effect as rst on all state and outputs.
- lap:
  - Write lap_time at wr_ptr; wr_ptr advances, wrapping DEPTH-1 -> 0.
  - lap_count increments, saturating at DEPTH.
  - If lap_count==DEPTH before the write, the oldest entry is overwritten and overflow is set.
  - lap_sel -> 0; lap_out <= lap_time on the same edge, so latency is 1 cycle, identical to a plain lap latch.
  - Any recall in the same cycle is ignored.
- Entry addressing: the viewed entry is mem[(wr_ptr - 1 - lap_sel) mod DEPTH], computed with explicit wrap; no reliance on power-of-two truncation.
- recall_prev alone (lap_count>0):
  - lap_sel <= lap_sel+1, wrapping lap_count-1 -> 0.
  - lap_out <= entry at the new lap_sel on the same edge (1-cycle latency).
- recall_next alone (lap_count>0):
  - lap_sel <= lap_sel-1, wrapping 0 -> lap_count-1.
  - lap_out updates as for recall_prev.
- recall_prev and recall_next asserted together: no change.
- Any recall with lap_count==0: ignored; lap_out stays 0.
- lap_count==1: recall wraps to itself; lap_sel stays 0.
- Overwrite while browsing is impossible: lap forces lap_sel=0.
- full is derived combinationally from registered lap_count and may not glitch externally; registering it is also acceptable.
- Reset asserted mid-browse or on the same cycle as lap: reset wins; nothing is written.

Optional Feature:
- Macro: LAP_HISTORY_DELTA_EN.
- Defined:
  - Adds output delta_out [4*DIGITS-1:0]: the split time of the viewed lap.
  - Value is lap_out minus the next-older stored entry, as per-digit decimal subtraction with borrow, modulo 10^DIGITS.
  - For the oldest valid entry (lap_sel==lap_count-1), or when lap_count<=1, delta_out = lap_out.
  - Registered and updated on the same edge as lap_out; reset value 0; cleared by clear.
- Undefined: port absent, no subtractor logic.

Test Plan:
- Reset then three laps with lap_time 0x0012, 0x0045, 0x0103 -> lap_count=3, lap_sel=0, lap_out=0x0103 the cycle after the third lap, full=0, overflow=0.
- From that state: recall_prev x2 -> lap_out 0x0045 then 0x0012. recall_prev again wraps -> 0x0103. recall_next from lap_sel=0 -> lap_sel=2, lap_out=0x0012.
- DEPTH=8, nine laps with values 1..9 (BCD) -> full=1, overflow=1, lap_count=8. Oldest visible (lap_sel=7) = 0x0002; value 1 is lost.
- Simultaneous lap=1 and recall_prev=1 with lap_time=0x0200 -> capture wins, lap_sel=0, lap_out=0x0200. Then recall_prev=1 and recall_next=1 together -> no change. Then clear -> all outputs 0, and a following recall_prev leaves lap_out=0.
- Empty buffer: recall_prev/recall_next pulses -> lap_sel=0, lap_out=0. rst asserted on the same cycle as lap -> lap_count stays 0.
- With LAP_HISTORY_DELTA_EN, laps 0x0058 then 0x0103 -> at lap_sel=0, delta_out=0x0045 (borrow across digits). At lap_sel=1, delta_out=0x0058.
